enemy_snapshot_adapter: RTL and testbench

- Parametrised successor to the fixed 4-slot spider-to-enemy mapping.
- Takes N_ENEMY enemy slots from any enemy-type generator (spiders and later types) and publishes a frame-stable, registered enemy table to the renderer and collision logic.
- The table is updated only on a frame tick.
- Adds a kill channel: collision logic kills a slot, the slot is hidden at once, the source is told to despawn it, and the slot stays masked until the source acknowledges the death.

---
 rtl/enemy_snapshot_adapter.sv | 100 ++++++++++
 tb/tb_enemy_snapshot_adapter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_snapshot_adapter.sv
// enemy_snapshot_adapter: frame-stable registered enemy table with a kill channel.
// Slots are refreshed on frame_tick; a killed slot is hidden at once and stays
// masked until the source drops its alive bit.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   src_x_flat        source x, slot i at [i*COORD_W +: COORD_W]
//   src_y_flat        source y, same packing
//   src_alive_flat    source alive bits
//   frame_tick        one-cycle pulse at frame boundary
//   kill_valid        kill request
//   kill_idx          slot to kill (ignored when >= N_ENEMY)
//   kill_ack          one-cycle pulse, kill accepted
//   kill_hit          with kill_ack: slot was alive in the table
//   despawn_flat      one-cycle one-hot despawn pulse to the source
//   enemy_x_flat      published x
//   enemy_y_flat      published y
//   enemy_alive_flat  published alive bits
//   alive_count       popcount of enemy_alive_flat
//   snap_valid        one-cycle pulse, table just refreshed
module enemy_snapshot_adapter #(
    parameter int N_ENEMY = 4,
    parameter int COORD_W = 10,
    parameter int CNT_W   = 6
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_ENEMY*COORD_W-1:0] src_x_flat,
    input  logic [N_ENEMY*COORD_W-1:0] src_y_flat,
    input  logic [N_ENEMY-1:0]         src_alive_flat,
    input  logic                       frame_tick,
    input  logic                       kill_valid,
    input  logic [4:0]                 kill_idx,
    output logic                       kill_ack,
    output logic                       kill_hit,
    output logic [N_ENEMY-1:0]         despawn_flat,
    output logic [N_ENEMY*COORD_W-1:0] enemy_x_flat,
    output logic [N_ENEMY*COORD_W-1:0] enemy_y_flat,
    output logic [N_ENEMY-1:0]         enemy_alive_flat,
    output logic [CNT_W-1:0]           alive_count,
    output logic                       snap_valid
);

    logic [N_ENEMY-1:0] kill_mask;
    logic [N_ENEMY-1:0] kill_onehot;
    logic [N_ENEMY-1:0] mask_next;
    logic [N_ENEMY-1:0] eff_alive;
    logic               kill_accept;
    logic               hit_now;
    logic [CNT_W-1:0]   eff_count;

    always_comb begin
        kill_accept = kill_valid && ({27'd0, kill_idx} < 32'(N_ENEMY));
        kill_onehot = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            kill_onehot[i] = kill_accept && (kill_idx == 5'(i));
        end
        // A mask bit survives only while the source still reports the slot
        // alive, so a lagging source cannot resurrect a killed enemy.
        mask_next = kill_onehot | (kill_mask & src_alive_flat);
        eff_alive = src_alive_flat & ~mask_next;
        // Hit is judged against the published table before this edge.
        hit_now   = |(enemy_alive_flat & kill_onehot);
        eff_count = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            eff_count = eff_count + CNT_W'(eff_alive[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kill_mask        <= '0;
            kill_ack         <= 1'b0;
            kill_hit         <= 1'b0;
            despawn_flat     <= '0;
            enemy_x_flat     <= '0;
            enemy_y_flat     <= '0;
            enemy_alive_flat <= '0;
            alive_count      <= '0;
            snap_valid       <= 1'b0;
        end else begin
            kill_mask    <= mask_next;
            kill_ack     <= kill_accept;
            kill_hit     <= kill_accept && hit_now;
            despawn_flat <= kill_onehot;
            snap_valid   <= frame_tick;
            if (frame_tick) begin
                // eff_alive already excludes a kill landing on this edge.
                enemy_x_flat     <= src_x_flat;
                enemy_y_flat     <= src_y_flat;
                enemy_alive_flat <= eff_alive;
                alive_count      <= eff_count;
            end else if (kill_accept) begin
                enemy_alive_flat <= enemy_alive_flat & ~kill_onehot;
                alive_count      <= alive_count - CNT_W'(hit_now);
            end
        end
    end

endmodule

// File: tb/tb_enemy_snapshot_adapter.sv
// Testbench for enemy_snapshot_adapter: a 4-slot and an 8-slot instance
// checked against directed vectors and a behavioural slot model.
module tb_enemy_snapshot_adapter;

    localparam int NA = 4;
    localparam int WA = 10;
    localparam int NB = 8;
    localparam int WB = 11;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic tick, kv;
    logic [4:0] ki;

    logic [NA*WA-1:0] a_sx, a_sy, a_ex, a_ey;
    logic [NA-1:0]    a_sa, a_ea, a_desp;
    logic [CW-1:0]    a_cnt;
    logic             a_ack, a_hit, a_snap;

    logic [NB*WB-1:0] b_sx, b_sy, b_ex, b_ey;
    logic [NB-1:0]    b_sa, b_ea, b_desp;
    logic [CW-1:0]    b_cnt;
    logic             b_ack, b_hit, b_snap;

    enemy_snapshot_adapter #(.N_ENEMY(NA), .COORD_W(WA), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .src_x_flat(a_sx), .src_y_flat(a_sy), .src_alive_flat(a_sa),
        .frame_tick(tick), .kill_valid(kv), .kill_idx(ki),
        .kill_ack(a_ack), .kill_hit(a_hit), .despawn_flat(a_desp),
        .enemy_x_flat(a_ex), .enemy_y_flat(a_ey), .enemy_alive_flat(a_ea),
        .alive_count(a_cnt), .snap_valid(a_snap)
    );

    enemy_snapshot_adapter #(.N_ENEMY(NB), .COORD_W(WB), .CNT_W(CW)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .src_x_flat(b_sx), .src_y_flat(b_sy), .src_alive_flat(b_sa),
        .frame_tick(tick), .kill_valid(kv), .kill_idx(ki),
        .kill_ack(b_ack), .kill_hit(b_hit), .despawn_flat(b_desp),
        .enemy_x_flat(b_ex), .enemy_y_flat(b_ey), .enemy_alive_flat(b_ea),
        .alive_count(b_cnt), .snap_valid(b_snap)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(string nm, logic [87:0] act, logic [87:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: per-slot arrays, count derived by summing.
    int mx[2][8];
    int my[2][8];
    bit malive[2][8];
    bit mmask[2][8];
    bit mack[2];
    bit mhit[2];
    bit msnap[2];
    int mdesp[2];

    function automatic int srcx(int d, int i);
        return d ? int'(b_sx[i*WB +: WB]) : int'(a_sx[i*WA +: WA]);
    endfunction

    function automatic int srcy(int d, int i);
        return d ? int'(b_sy[i*WB +: WB]) : int'(a_sy[i*WA +: WA]);
    endfunction

    function automatic bit srca(int d, int i);
        return d ? b_sa[i] : a_sa[i];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                mx[d][i] = 0;
                my[d][i] = 0;
                malive[d][i] = 0;
                mmask[d][i] = 0;
            end
            mack[d] = 0;
            mhit[d] = 0;
            msnap[d] = 0;
            mdesp[d] = -1;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            int n = d ? NB : NA;
            bit acc;
            bit h;
            bit nm[8];
            acc = kv && (int'(ki) < n);
            h = 0;
            if (acc) h = malive[d][ki];
            for (int i = 0; i < 8; i++) begin
                if (acc && int'(ki) == i) nm[i] = 1;
                else if (i < n && srca(d, i)) nm[i] = mmask[d][i];
                else nm[i] = 0;
            end
            if (tick) begin
                for (int i = 0; i < n; i++) begin
                    mx[d][i] = srcx(d, i);
                    my[d][i] = srcy(d, i);
                    malive[d][i] = srca(d, i) && !nm[i];
                end
            end else if (acc) begin
                malive[d][ki] = 0;
            end
            for (int i = 0; i < 8; i++) mmask[d][i] = nm[i];
            mack[d] = acc;
            mhit[d] = h;
            msnap[d] = tick;
            mdesp[d] = acc ? int'(ki) : -1;
        end
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            int n = d ? NB : NA;
            int w = d ? WB : WA;
            logic [87:0] ex, ey, ea, ed;
            int cnt;
            ex = '0;
            ey = '0;
            ea = '0;
            cnt = 0;
            for (int i = 0; i < n; i++) begin
                ex = ex | (88'(mx[d][i]) << (i * w));
                ey = ey | (88'(my[d][i]) << (i * w));
                ea[i] = malive[d][i];
                cnt += int'(malive[d][i]);
            end
            ed = (mdesp[d] >= 0) ? (88'(1) << mdesp[d]) : '0;
            chk(d ? "b_x" : "a_x", d ? 88'(b_ex) : 88'(a_ex), ex);
            chk(d ? "b_y" : "a_y", d ? 88'(b_ey) : 88'(a_ey), ey);
            chk(d ? "b_alive" : "a_alive", d ? 88'(b_ea) : 88'(a_ea), ea);
            chk(d ? "b_count" : "a_count", d ? 88'(b_cnt) : 88'(a_cnt), 88'(cnt));
            chk(d ? "b_ack" : "a_ack", d ? 88'(b_ack) : 88'(a_ack), 88'(mack[d]));
            chk(d ? "b_hit" : "a_hit", d ? 88'(b_hit) : 88'(a_hit), 88'(mhit[d]));
            chk(d ? "b_desp" : "a_desp", d ? 88'(b_desp) : 88'(a_desp), ed);
            chk(d ? "b_snap" : "a_snap", d ? 88'(b_snap) : 88'(a_snap), 88'(msnap[d]));
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    // Directed sources: 4-slot gets small values, 8-slot gets values near 2^11-1.
    function automatic logic [NA*WA-1:0] ax(bit alt);
        logic [NA*WA-1:0] v;
        for (int i = 0; i < NA; i++) v[i*WA +: WA] = WA'(alt ? (i + 1) * 100 : (i + 1) * 10);
        return v;
    endfunction

    function automatic logic [NA*WA-1:0] ay(bit alt);
        logic [NA*WA-1:0] v;
        for (int i = 0; i < NA; i++) v[i*WA +: WA] = WA'(alt ? (i + 5) * 10 : i + 5);
        return v;
    endfunction

    task automatic set_src(bit alt);
        a_sx = ax(alt);
        a_sy = ay(alt);
        for (int i = 0; i < NB; i++) begin
            b_sx[i*WB +: WB] = WB'(alt ? 1030 + i : 2047 - i);
            b_sy[i*WB +: WB] = WB'(alt ? 1024 + i : 2040 - i);
        end
    endtask

    task automatic check_zero();
        chk("rst_a_x", 88'(a_ex), '0);
        chk("rst_a_y", 88'(a_ey), '0);
        chk("rst_a_alive", 88'(a_ea), '0);
        chk("rst_a_ctl", 88'({a_cnt, a_ack, a_hit, a_snap, a_desp}), '0);
        chk("rst_b_x", 88'(b_ex), '0);
        chk("rst_b_y", 88'(b_ey), '0);
        chk("rst_b_alive", 88'(b_ea), '0);
        chk("rst_b_ctl", 88'({b_cnt, b_ack, b_hit, b_snap, b_desp}), '0);
    endtask

    typedef struct {
        logic [7:0] sa;
        logic       tk;
        logic       kv;
        logic [4:0] ki;
        logic       alt;
        logic [3:0] ea;
        int         cnt;
        logic       ack;
        logic       hit;
        logic [3:0] desp;
        logic       snap;
        logic       ealt;
    } vec_t;

    vec_t v[14];

    initial begin
        v[0]  = '{8'hFB, 1, 0, 5'd0, 0, 4'b1011, 3, 0, 0, 4'b0000, 1, 0};
        v[1]  = '{8'hFB, 0, 0, 5'd0, 1, 4'b1011, 3, 0, 0, 4'b0000, 0, 0};
        v[2]  = '{8'hFB, 0, 1, 5'd1, 0, 4'b1001, 2, 1, 1, 4'b0010, 0, 0};
        v[3]  = '{8'hFB, 1, 0, 5'd0, 0, 4'b1001, 2, 0, 0, 4'b0000, 1, 0};
        v[4]  = '{8'hFB, 1, 0, 5'd0, 0, 4'b1001, 2, 0, 0, 4'b0000, 1, 0};
        v[5]  = '{8'hF9, 0, 0, 5'd0, 0, 4'b1001, 2, 0, 0, 4'b0000, 0, 0};
        v[6]  = '{8'hFB, 0, 0, 5'd0, 0, 4'b1001, 2, 0, 0, 4'b0000, 0, 0};
        v[7]  = '{8'hFB, 1, 0, 5'd0, 0, 4'b1011, 3, 0, 0, 4'b0000, 1, 0};
        v[8]  = '{8'hFB, 0, 1, 5'd2, 0, 4'b1011, 3, 1, 0, 4'b0100, 0, 0};
        v[9]  = '{8'hFB, 0, 1, 5'd7, 0, 4'b1011, 3, 0, 0, 4'b0000, 0, 0};
        v[10] = '{8'hFF, 1, 1, 5'd0, 0, 4'b1110, 3, 1, 1, 4'b0001, 1, 0};
        v[11] = '{8'hFF, 0, 1, 5'd0, 0, 4'b1110, 3, 1, 0, 4'b0001, 0, 0};
        v[12] = '{8'hFF, 0, 1, 5'd1, 0, 4'b1100, 2, 1, 1, 4'b0010, 0, 0};
        v[13] = '{8'hFF, 0, 1, 5'd3, 0, 4'b0100, 1, 1, 1, 4'b1000, 0, 0};

        tick = 0;
        kv = 0;
        ki = '0;
        a_sa = '0;
        b_sa = '0;
        set_src(0);
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_zero();
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int r = 0; r < 14; r++) begin
            set_src(v[r].alt);
            a_sa = v[r].sa[3:0];
            b_sa = v[r].sa;
            tick = v[r].tk;
            kv = v[r].kv;
            ki = v[r].ki;
            step();
            chk($sformatf("vec%0d_alive", r), 88'(a_ea), 88'(v[r].ea));
            chk($sformatf("vec%0d_count", r), 88'(a_cnt), 88'(v[r].cnt));
            chk($sformatf("vec%0d_ackhit", r), 88'({a_ack, a_hit}), 88'({v[r].ack, v[r].hit}));
            chk($sformatf("vec%0d_desp", r), 88'(a_desp), 88'(v[r].desp));
            chk($sformatf("vec%0d_snap", r), 88'(a_snap), 88'(v[r].snap));
            chk($sformatf("vec%0d_x", r), 88'(a_ex), 88'(ax(v[r].ealt)));
            chk($sformatf("vec%0d_y", r), 88'(a_ey), 88'(ay(v[r].ealt)));
        end

        // Reset lands mid-cycle while a kill is being requested.
        kv = 1;
        ki = 5'd2;
        #3 rst_n = 1'b0;
        #1 check_zero();
        model_reset();
        kv = 0;
        @(posedge clk);
        #1 check_zero();
        rst_n = 1'b1;

        // Cleared masks let every slot publish; counts reach N.
        a_sa = '1;
        b_sa = '1;
        tick = 1;
        step();
        chk("full_a_count", 88'(a_cnt), 88'(4));
        chk("full_b_count", 88'(b_cnt), 88'(8));
        chk("full_b_x_top", 88'(b_ex[7*WB +: WB]), 88'(2040));
        chk("full_b_x_low", 88'(b_ex[0 +: WB]), 88'(2047));

        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3, 0) == 0) begin
                a_sa = NA'($urandom);
                b_sa = NB'($urandom) | NB'($urandom);
            end
            if ($urandom_range(2, 0) == 0) begin
                for (int i = 0; i < NA; i++) a_sx[i*WA +: WA] = WA'($urandom);
                for (int i = 0; i < NA; i++) a_sy[i*WA +: WA] = WA'($urandom);
                for (int i = 0; i < NB; i++) b_sx[i*WB +: WB] = WB'($urandom_range(2047, 1500));
                for (int i = 0; i < NB; i++) b_sy[i*WB +: WB] = WB'($urandom);
            end
            tick = ($urandom_range(3, 0) == 0);
            kv = ($urandom_range(1, 0) == 1);
            ki = 5'($urandom_range(9, 0));
            step();
        end

        tick = 0;
        kv = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
